// File: rtl/betting_sequencer.sv
// Turn-order and betting-round sequencer for a four-seat card table.
// Walks a hand through preflop..river, tracks who is still in and who owes action.
module betting_sequencer #(
  parameter int NPLAYERS   = 4,
  parameter int TIMEOUT    = 200,
  parameter int MAX_RAISES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_game,
  input  logic       act_valid,
  input  logic [1:0] act_player,
  input  logic [1:0] act_code,
  output logic       act_ready,
  output logic       turn_valid,
  output logic [1:0] turn_player,
  output logic       advance,
  output logic       reset_game,
  output logic [2:0] stage,
  output logic [3:0] active_mask,
  output logic       winner_valid,
  output logic [1:0] winner_player
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RAISES > 0) ? $clog2(MAX_RAISES + 1) : 1;
  localparam logic [3:0]    ALL_SEATS  = 4'((1 << NPLAYERS) - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RAISE_CAP  = RW'(MAX_RAISES);
  localparam logic [1:0]    CODE_RAISE = 2'b01;
  localparam logic [1:0]    CODE_FOLD  = 2'b10;

  typedef enum logic [2:0] {IDLE, ADV, BET, SHOW, DONE} state_t;

  state_t        state, state_n;
  logic [2:0]    stage_n;
  logic [1:0]    dealer, dealer_n;
  logic [3:0]    active_n, pending, pending_n;
  logic [RW-1:0] raise_cnt, raise_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    turn_n, winner_n;
  logic          win_pulse_n;
  logic [3:0]    seat_bit, live_n, owe_n;
  logic [1:0]    code;
  logic          accept, expired, can_raise;

  // First seat at or after 'from' (wrapping) whose bit is set in mask.
  function automatic logic [1:0] first_set(input logic [3:0] mask, input logic [1:0] from);
    logic [1:0] seat;
    first_set = from;
    for (int k = 3; k >= 0; k--) begin
      seat = from + 2'(k);
      if (mask[seat]) first_set = seat;
    end
  endfunction

  function automatic logic only_one(input logic [3:0] mask);
    return (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] seat_of(input logic [3:0] onehot);
    seat_of = 2'd0;
    for (int i = 0; i < 4; i++) if (onehot[i]) seat_of = 2'(i);
  endfunction

  assign turn_valid = (state == BET);
  assign advance    = (state == ADV);
  assign reset_game = (state == DONE);
  assign act_ready  = turn_valid && (act_player == turn_player);

  always_comb begin
    state_n     = state;
    stage_n     = stage;
    dealer_n    = dealer;
    active_n    = active_mask;
    pending_n   = pending;
    raise_n     = raise_cnt;
    timer_n     = timer;
    turn_n      = turn_player;
    winner_n    = winner_player;
    win_pulse_n = 1'b0;

    seat_bit  = 4'b0001 << turn_player;
    accept    = act_valid && act_ready;
    // A seat that sits on the turn too long is folded as if it had folded itself.
    expired   = !accept && (timer == TIMER_LAST);
    code      = expired ? CODE_FOLD : act_code;
    can_raise = (raise_cnt < RAISE_CAP);
    live_n    = active_mask;
    owe_n     = pending & ~seat_bit;
    if (code == CODE_FOLD) live_n = active_mask & ~seat_bit;
    else if (code == CODE_RAISE && can_raise) owe_n = active_mask & ~seat_bit;

    case (state)
      IDLE: begin
        if (start_game) begin
          active_n = ALL_SEATS;
          state_n  = ADV;
        end
      end
      ADV: begin
        stage_n = stage + 3'd1;
        if (stage_n <= 3'd4) begin
          pending_n = active_mask;
          raise_n   = '0;
          timer_n   = '0;
          turn_n    = first_set(active_mask, dealer + 2'd1);
          state_n   = BET;
        end else begin
          state_n = SHOW;
        end
      end
      BET: begin
        if (accept || expired) begin
          timer_n   = '0;
          active_n  = live_n;
          pending_n = owe_n;
          if (code == CODE_RAISE && can_raise) raise_n = raise_cnt + 1'b1;
          if (code == CODE_FOLD && only_one(live_n)) begin
            winner_n    = seat_of(live_n);
            win_pulse_n = 1'b1;
            state_n     = DONE;
          end else if (owe_n == 4'd0) begin
            state_n = ADV;
          end else begin
            turn_n = first_set(owe_n, turn_player + 2'd1);
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      SHOW: state_n = DONE;
      DONE: begin
        stage_n  = 3'd0;
        dealer_n = dealer + 2'd1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      stage         <= 3'd0;
      dealer        <= 2'd0;
      active_mask   <= 4'd0;
      pending       <= 4'd0;
      raise_cnt     <= '0;
      timer         <= '0;
      turn_player   <= 2'd0;
      winner_player <= 2'd0;
      winner_valid  <= 1'b0;
    end else begin
      state         <= state_n;
      stage         <= stage_n;
      dealer        <= dealer_n;
      active_mask   <= active_n;
      pending       <= pending_n;
      raise_cnt     <= raise_n;
      timer         <= timer_n;
      turn_player   <= turn_n;
      winner_player <= winner_n;
      winner_valid  <= win_pulse_n;
    end
  end

endmodule

// File: tb/tb_betting_sequencer.sv
// Bench for betting_sequencer: directed scenarios plus random hands against a rule-level table model.
module tb_betting_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1, start_game = 1'b0, act_valid = 1'b0;
  logic [1:0] act_player = 2'd0, act_code = 2'd0;
  logic       act_ready, turn_valid, advance, reset_game, winner_valid;
  logic [1:0] turn_player, winner_player;
  logic [2:0] stage;
  logic [3:0] active_mask;
  int total = 0, bad = 0;

  // Table model: who is in, who still owes action, whose turn, and hand progress.
  int m_in[4], m_owe[4];
  int m_raises, m_turn, m_dealer, m_stage, m_winner;

  betting_sequencer #(.NPLAYERS(4), .TIMEOUT(200), .MAX_RAISES(3)) dut (
    .clk(clk), .reset(reset), .start_game(start_game), .act_valid(act_valid),
    .act_player(act_player), .act_code(act_code), .act_ready(act_ready),
    .turn_valid(turn_valid), .turn_player(turn_player), .advance(advance),
    .reset_game(reset_game), .stage(stage), .active_mask(active_mask),
    .winner_valid(winner_valid), .winner_player(winner_player));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic act(input int seat, input int code);
    act_valid  = 1'b1;
    act_player = 2'(seat);
    act_code   = 2'(code);
    tick();
    act_valid = 1'b0;
  endtask

  function automatic logic [3:0] m_mask();
    logic [3:0] m = 4'd0;
    for (int i = 0; i < 4; i++) if (m_in[i] != 0) m[i] = 1'b1;
    return m;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) begin m_in[i] = 0; m_owe[i] = 0; end
    m_raises = 0; m_turn = 0; m_dealer = 0; m_stage = 0; m_winner = 0;
  endfunction

  function automatic void m_next_round();
    m_stage++;
    if (m_stage <= 4) begin
      for (int i = 0; i < 4; i++) m_owe[i] = m_in[i];
      m_raises = 0;
      for (int k = 3; k >= 0; k--) if (m_in[(m_dealer + 1 + k) % 4] != 0) m_turn = (m_dealer + 1 + k) % 4;
    end
  endfunction

  // Returns 0 = play continues, 1 = round complete, 2 = hand won by last seat.
  function automatic int m_act(input int code);
    int live = 0;
    if (code == 2) begin
      m_in[m_turn] = 0;
      m_owe[m_turn] = 0;
    end else if (code == 1 && m_raises < 3) begin
      for (int i = 0; i < 4; i++) m_owe[i] = (m_in[i] != 0 && i != m_turn) ? 1 : 0;
      m_raises++;
    end else begin
      m_owe[m_turn] = 0;
    end
    for (int i = 0; i < 4; i++) live += m_in[i];
    if (code == 2 && live == 1) begin
      for (int i = 0; i < 4; i++) if (m_in[i] != 0) m_winner = i;
      return 2;
    end
    for (int k = 1; k <= 4; k++) begin
      if (m_owe[(m_turn + k) % 4] != 0) begin
        m_turn = (m_turn + k) % 4;
        return 0;
      end
    end
    return 1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_clear();
  endtask

  task automatic start_hand();
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    for (int i = 0; i < 4; i++) m_in[i] = 1;
    m_stage = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_game = 1'b1; act_valid = 1'b1; act_player = 2'd0; act_code = 2'd1;
    tick(); tick();
    start_game = 1'b0; act_valid = 1'b0;
    total++;
    if ({turn_valid, advance, reset_game, winner_valid} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses: got tv/adv/rg/wv=%b want 0000", {turn_valid, advance, reset_game, winner_valid});
    end
    total++;
    if (stage !== 3'd0 || active_mask !== 4'd0) begin
      bad++; $display("FAIL reset_state: got stage=%0d mask=%h want 0 0", stage, active_mask);
    end
    total++;
    if (turn_player !== 2'd0 || winner_player !== 2'd0 || act_ready !== 1'b0) begin
      bad++; $display("FAIL reset_seats: got tp=%0d wp=%0d ready=%b want 0 0 0", turn_player, winner_player, act_ready);
    end
    reset = 1'b0; m_clear();
    tick();
    total++;
    if (advance !== 1'b0 || active_mask !== 4'd0) begin
      bad++; $display("FAIL reset_idle: got adv=%b mask=%h want 0 0", advance, active_mask);
    end
  endtask

  task automatic test_all_call();
    do_reset();
    start_hand();
    total++;
    if (advance !== 1'b1 || stage !== 3'd0 || active_mask !== 4'hF) begin
      bad++; $display("FAIL call_start: got adv=%b stage=%0d mask=%h want 1 0 f", advance, stage, active_mask);
    end
    for (int r = 1; r <= 4; r++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        start_game = 1'b1;
        total++;
        if (turn_valid !== 1'b1 || turn_player !== 2'((1 + k) % 4) || stage !== 3'(r)) begin
          bad++; $display("FAIL call_turn: round %0d got tv=%b tp=%0d stage=%0d want 1 %0d %0d", r, turn_valid, turn_player, stage, (1 + k) % 4, r);
        end
        act((1 + k) % 4, 0);
        start_game = 1'b0;
      end
      total++;
      if (advance !== 1'b1 || turn_valid !== 1'b0 || reset_game !== 1'b0) begin
        bad++; $display("FAIL call_adv: round %0d got adv=%b tv=%b rg=%b want 1 0 0", r, advance, turn_valid, reset_game);
      end
    end
    tick();
    total++;
    if (stage !== 3'd5 || advance !== 1'b0 || turn_valid !== 1'b0 || reset_game !== 1'b0) begin
      bad++; $display("FAIL call_show: got stage=%0d adv=%b tv=%b rg=%b want 5 0 0 0", stage, advance, turn_valid, reset_game);
    end
    tick();
    total++;
    if (reset_game !== 1'b1 || advance !== 1'b0 || winner_valid !== 1'b0) begin
      bad++; $display("FAIL call_done: got rg=%b adv=%b wv=%b want 1 0 0", reset_game, advance, winner_valid);
    end
    tick();
    total++;
    if (stage !== 3'd0 || reset_game !== 1'b0) begin
      bad++; $display("FAIL call_idle: got stage=%0d rg=%b want 0 0", stage, reset_game);
    end
    start_hand(); tick();
    total++;
    if (turn_valid !== 1'b1 || turn_player !== 2'd2) begin
      bad++; $display("FAIL call_dealer: got tv=%b first turn=%0d want 1 2", turn_valid, turn_player);
    end
  endtask

  task automatic test_reraise();
    int seats[5] = '{1, 2, 3, 0, 1};
    int codes[5] = '{0, 1, 0, 0, 0};
    do_reset(); start_hand(); tick();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (turn_valid !== 1'b1 || turn_player !== 2'(seats[k])) begin
        bad++; $display("FAIL reraise_turn: step %0d got tv=%b tp=%0d want 1 %0d", k, turn_valid, turn_player, seats[k]);
      end
      act(seats[k], codes[k]);
    end
    total++;
    if (advance !== 1'b1 || stage !== 3'd1) begin
      bad++; $display("FAIL reraise_adv: got adv=%b stage=%0d want 1 1", advance, stage);
    end
  endtask

  task automatic test_winner();
    do_reset(); start_hand(); tick();
    for (int s = 1; s <= 3; s++) begin
      total++;
      if (turn_player !== 2'(s) || winner_valid !== 1'b0) begin
        bad++; $display("FAIL win_turn: got tp=%0d wv=%b want %0d 0", turn_player, winner_valid, s);
      end
      act(s, 2);
    end
    total++;
    if (winner_valid !== 1'b1 || winner_player !== 2'd0 || reset_game !== 1'b1 || advance !== 1'b0 || active_mask !== 4'h1) begin
      bad++; $display("FAIL win_pulse: got wv=%b wp=%0d rg=%b adv=%b mask=%h want 1 0 1 0 1", winner_valid, winner_player, reset_game, advance, active_mask);
    end
    tick();
    total++;
    if (winner_valid !== 1'b0 || reset_game !== 1'b0 || advance !== 1'b0 || stage !== 3'd0 || turn_valid !== 1'b0) begin
      bad++; $display("FAIL win_after: got wv=%b rg=%b adv=%b stage=%0d tv=%b want 0 0 0 0 0", winner_valid, reset_game, advance, stage, turn_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset(); start_hand(); tick();
    repeat (199) tick();
    total++;
    if (turn_player !== 2'd1 || active_mask !== 4'hF) begin
      bad++; $display("FAIL tmo_early: after 199 cycles got tp=%0d mask=%h want 1 f", turn_player, active_mask);
    end
    tick();
    total++;
    if (turn_valid !== 1'b1 || turn_player !== 2'd2 || active_mask !== 4'hD) begin
      bad++; $display("FAIL tmo_fold: after 200 cycles got tv=%b tp=%0d mask=%h want 1 2 d", turn_valid, turn_player, active_mask);
    end
  endtask

  task automatic test_raise_cap();
    do_reset(); start_hand(); tick();
    act(1, 1); act(2, 1); act(3, 1); act(0, 1);
    total++;
    if (turn_player !== 2'd1 || advance !== 1'b0) begin
      bad++; $display("FAIL cap_turn: got tp=%0d adv=%b want 1 0", turn_player, advance);
    end
    act(1, 0); act(2, 0);
    total++;
    if (advance !== 1'b1 || turn_valid !== 1'b0) begin
      bad++; $display("FAIL cap_round: got adv=%b tv=%b tp=%0d want 1 0", advance, turn_valid, turn_player);
    end
  endtask

  task automatic test_stray_and_reset();
    do_reset(); start_hand(); tick();
    act_valid = 1'b1; act_player = 2'd2; act_code = 2'd2;
    #1;
    total++;
    if (act_ready !== 1'b0) begin
      bad++; $display("FAIL stray_ready: got %b want 0", act_ready);
    end
    tick();
    act_valid = 1'b0;
    total++;
    if (turn_valid !== 1'b1 || turn_player !== 2'd1 || active_mask !== 4'hF) begin
      bad++; $display("FAIL stray_state: got tv=%b tp=%0d mask=%h want 1 1 f", turn_valid, turn_player, active_mask);
    end
    act_player = 2'd1;
    #1;
    total++;
    if (act_ready !== 1'b1) begin
      bad++; $display("FAIL own_ready: got %b want 1", act_ready);
    end
    reset = 1'b1; act_valid = 1'b1; act_code = 2'd2;
    tick();
    act_valid = 1'b0;
    total++;
    if ({turn_valid, advance, reset_game, winner_valid} !== 4'b0000 || stage !== 3'd0 || active_mask !== 4'd0 || turn_player !== 2'd0) begin
      bad++; $display("FAIL midhand_reset: got tv/adv/rg/wv=%b stage=%0d mask=%h tp=%0d want 0000 0 0 0", {turn_valid, advance, reset_game, winner_valid}, stage, active_mask, turn_player);
    end
    reset = 1'b0;
    tick();
    total++;
    if (reset_game !== 1'b0 || advance !== 1'b0) begin
      bad++; $display("FAIL midhand_after: got rg=%b adv=%b want 0 0", reset_game, advance);
    end
    m_clear();
  endtask

  task automatic test_random_hands();
    int oc, code, r;
    bit done;
    do_reset();
    for (int h = 0; h < 12; h++) begin
      start_hand();
      total++;
      if (advance !== 1'b1 || stage !== 3'd0) begin
        bad++; $display("FAIL rnd_start: hand %0d got adv=%b stage=%0d want 1 0", h, advance, stage);
      end
      tick(); m_next_round();
      done = 1'b0;
      for (int g = 0; g < 100 && !done; g++) begin
        total++;
        if (turn_valid !== 1'b1 || turn_player !== 2'(m_turn) || active_mask !== m_mask() || stage !== 3'(m_stage)) begin
          bad++; $display("FAIL rnd_turn: got tv=%b tp=%0d mask=%h stage=%0d want 1 %0d %h %0d", turn_valid, turn_player, active_mask, stage, m_turn, m_mask(), m_stage);
        end
        if ($urandom_range(3) == 0) begin
          act((m_turn + int'($urandom_range(3, 1))) % 4, int'($urandom_range(3)));
          total++;
          if (turn_player !== 2'(m_turn) || active_mask !== m_mask()) begin
            bad++; $display("FAIL rnd_stray: got tp=%0d mask=%h want %0d %h", turn_player, active_mask, m_turn, m_mask());
          end
        end
        start_game = 1'($urandom_range(1));
        repeat ($urandom_range(2)) tick();
        start_game = 1'b0;
        r = int'($urandom_range(9));
        code = (r < 4) ? 0 : (r == 4) ? 3 : (r < 8) ? 1 : 2;
        act_player = 2'(m_turn);
        #1;
        total++;
        if (act_ready !== 1'b1) begin
          bad++; $display("FAIL rnd_ready: got %b want 1 for seat %0d", act_ready, m_turn);
        end
        act(m_turn, code);
        oc = m_act(code == 3 ? 0 : code);
        if (oc == 2) begin
          total++;
          if (winner_valid !== 1'b1 || winner_player !== 2'(m_winner) || reset_game !== 1'b1 || turn_valid !== 1'b0 || advance !== 1'b0) begin
            bad++; $display("FAIL rnd_win: got wv=%b wp=%0d rg=%b tv=%b adv=%b want 1 %0d 1 0 0", winner_valid, winner_player, reset_game, turn_valid, advance, m_winner);
          end
          tick();
          total++;
          if (winner_valid !== 1'b0 || reset_game !== 1'b0 || stage !== 3'd0 || winner_player !== 2'(m_winner)) begin
            bad++; $display("FAIL rnd_win_after: got wv=%b rg=%b stage=%0d wp=%0d want 0 0 0 %0d", winner_valid, reset_game, stage, winner_player, m_winner);
          end
          m_dealer = (m_dealer + 1) % 4; m_stage = 0; done = 1'b1;
        end else if (oc == 1) begin
          total++;
          if (advance !== 1'b1 || turn_valid !== 1'b0 || reset_game !== 1'b0 || stage !== 3'(m_stage)) begin
            bad++; $display("FAIL rnd_adv: got adv=%b tv=%b rg=%b stage=%0d want 1 0 0 %0d", advance, turn_valid, reset_game, stage, m_stage);
          end
          tick(); m_next_round();
          if (m_stage > 4) begin
            total++;
            if (stage !== 3'd5 || advance !== 1'b0 || turn_valid !== 1'b0 || reset_game !== 1'b0 || winner_valid !== 1'b0) begin
              bad++; $display("FAIL rnd_show: got stage=%0d adv=%b tv=%b rg=%b wv=%b want 5 0 0 0 0", stage, advance, turn_valid, reset_game, winner_valid);
            end
            tick();
            total++;
            if (reset_game !== 1'b1 || advance !== 1'b0 || winner_valid !== 1'b0) begin
              bad++; $display("FAIL rnd_done: got rg=%b adv=%b wv=%b want 1 0 0", reset_game, advance, winner_valid);
            end
            tick();
            total++;
            if (stage !== 3'd0 || reset_game !== 1'b0) begin
              bad++; $display("FAIL rnd_idle: got stage=%0d rg=%b want 0 0", stage, reset_game);
            end
            m_dealer = (m_dealer + 1) % 4; m_stage = 0; done = 1'b1;
          end
        end
      end
      if (!done) begin
        total++; bad++;
        $display("FAIL rnd_guard: hand %0d still running after 100 turns", h);
        do_reset();
      end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_all_call();
    test_reraise();
    test_winner();
    test_timeout();
    test_raise_cap();
    test_stray_and_reset();
    test_random_hands();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
